// File: rtl/sintable_phase_gen.sv
// Phase accumulator with programmable offset and linear FTW sweep, feeding an 8-bit sine table.
// Optional SINTABLE_PHASE_GEN_SYNC_EN adds i_sync to clear the accumulator synchronously.
module sintable_phase_gen #(
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_ce,
    input  logic                 i_ftw_wr,
    input  logic [ACC_WIDTH-1:0] i_ftw,
    input  logic                 i_offset_wr,
    input  logic [7:0]           i_offset,
    input  logic                 i_sweep_start,
    input  logic [ACC_WIDTH-1:0] i_sweep_step,
    input  logic [CNT_WIDTH-1:0] i_sweep_len,
`ifdef SINTABLE_PHASE_GEN_SYNC_EN
    input  logic                 i_sync,
`endif
    output logic [7:0]           o_phase,
    output logic                 o_valid,
    output logic                 o_wrap,
    output logic                 o_busy
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t               state, state_nx;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] ftw, ftw_nx;
    logic [ACC_WIDTH-1:0] step, step_nx;
    logic [CNT_WIDTH-1:0] cnt, cnt_nx;
    logic [7:0]           offset;
    logic [ACC_WIDTH:0]   sum;

    // Extra top bit captures the accumulator carry for o_wrap.
    assign sum = {1'b0, acc} + {1'b0, ftw};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_nx = state;
        ftw_nx   = ftw;
        step_nx  = step;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (i_ftw_wr) begin
                    ftw_nx = i_ftw;
                end else if (i_sweep_start && (i_sweep_len != '0)) begin
                    state_nx = SWEEP;
                    step_nx  = i_sweep_step;
                    cnt_nx   = i_sweep_len;
                end
            end
            SWEEP: begin
                // A tuning-word load aborts the sweep and suppresses this cycle's step.
                if (i_ftw_wr) begin
                    ftw_nx   = i_ftw;
                    state_nx = IDLE;
                end else if (i_ce) begin
                    ftw_nx = ftw + step;
                    cnt_nx = cnt - CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(1)) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state  <= IDLE;
            ftw    <= '0;
            step   <= '0;
            cnt    <= '0;
            offset <= '0;
            o_busy <= 1'b0;
        end else begin
            state  <= state_nx;
            ftw    <= ftw_nx;
            step   <= step_nx;
            cnt    <= cnt_nx;
            o_busy <= (state_nx == SWEEP);
            if (i_offset_wr) offset <= i_offset;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc <= '0;
`ifdef SINTABLE_PHASE_GEN_SYNC_EN
        end else if (i_sync) begin
            acc <= '0;
`endif
        end else if (i_ce) begin
            acc <= sum[ACC_WIDTH-1:0];
        end
    end

    // Output sample is taken from the pre-increment accumulator and pre-load offset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_phase <= '0;
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
        end else if (i_ce) begin
            o_phase <= acc[ACC_WIDTH-1 -: 8] + offset;
            o_valid <= 1'b1;
            o_wrap  <= sum[ACC_WIDTH];
        end else begin
            o_valid <= 1'b0;
            o_wrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sintable_phase_gen.sv
// Self-checking bench for sintable_phase_gen: directed scenarios plus randomized traffic
// against a behavioural model; SINTABLE_PHASE_GEN_SYNC_EN enables the i_sync checks.
module tb_sintable_phase_gen;

    localparam int AW = 24;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          ftw_wr;
    logic [AW-1:0] ftw_in;
    logic          offset_wr;
    logic [7:0]    offset_in;
    logic          sweep_start;
    logic [AW-1:0] step_in;
    logic [CW-1:0] len_in;
    logic          sync;
    logic [7:0]    o_phase;
    logic          o_valid;
    logic          o_wrap;
    logic          o_busy;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    sintable_phase_gen #(.ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_ce          (ce),
        .i_ftw_wr      (ftw_wr),
        .i_ftw         (ftw_in),
        .i_offset_wr   (offset_wr),
        .i_offset      (offset_in),
        .i_sweep_start (sweep_start),
        .i_sweep_step  (step_in),
        .i_sweep_len   (len_in),
`ifdef SINTABLE_PHASE_GEN_SYNC_EN
        .i_sync        (sync),
`endif
        .o_phase       (o_phase),
        .o_valid       (o_valid),
        .o_wrap        (o_wrap),
        .o_busy        (o_busy)
    );

    always #5 clk = ~clk;

    // Behavioural model: phase as a number, sweep as "remaining samples".
    logic [AW-1:0] m_acc, m_ftw, m_step;
    logic [7:0]    m_offset;
    int            m_left;
    logic [7:0]    e_phase;
    logic          e_valid, e_wrap, e_busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = '0; m_ftw = '0; m_step = '0; m_offset = '0; m_left = 0;
        e_phase = '0; e_valid = 1'b0; e_wrap = 1'b0; e_busy = 1'b0;
    endtask

    task automatic model_update();
        logic [AW:0] total_sum;
        if (rst) begin
            model_reset();
            return;
        end
        total_sum = {1'b0, m_acc} + {1'b0, m_ftw};
        e_valid = ce;
        e_wrap  = ce & total_sum[AW];
        if (ce) e_phase = m_acc[AW-1:AW-8] + m_offset;
`ifdef SINTABLE_PHASE_GEN_SYNC_EN
        if (sync) m_acc = '0;
        else if (ce) m_acc = total_sum[AW-1:0];
`else
        if (ce) m_acc = total_sum[AW-1:0];
`endif
        if (m_left > 0) begin
            if (ftw_wr) begin
                m_ftw  = ftw_in;
                m_left = 0;
            end else if (ce) begin
                m_ftw  = m_ftw + m_step;
                m_left = m_left - 1;
            end
        end else if (ftw_wr) begin
            m_ftw = ftw_in;
        end else if (sweep_start && len_in != 0) begin
            m_step = step_in;
            m_left = int'(len_in);
        end
        if (offset_wr) m_offset = offset_in;
        e_busy = (m_left > 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("phase", 32'(o_phase), 32'(e_phase));
            check("valid", 32'(o_valid), 32'(e_valid));
            check("wrap",  32'(o_wrap),  32'(e_wrap));
            check("busy",  32'(o_busy),  32'(e_busy));
        end
    end

    logic [7:0] cap_phase[$];
    logic       cap_wrap[$];
    int         busy_cycles;

    task automatic tick();
        @(posedge clk);
        #1;
        model_update();
        if (o_valid) begin
            cap_phase.push_back(o_phase);
            cap_wrap.push_back(o_wrap);
        end
        if (o_busy) busy_cycles++;
        @(negedge clk);
    endtask

    task automatic clear_strobes();
        ftw_wr = 1'b0; offset_wr = 1'b0; sweep_start = 1'b0; sync = 1'b0;
    endtask

    task automatic do_reset();
        clear_strobes();
        ce  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cap_phase.delete();
        cap_wrap.delete();
        busy_cycles = 0;
    endtask

    task automatic load(input logic [AW-1:0] f, input logic [7:0] off);
        ftw_in = f; ftw_wr = 1'b1; offset_in = off; offset_wr = 1'b1; ce = 1'b0;
        tick();
        clear_strobes();
        cap_phase.delete();
        cap_wrap.delete();
    endtask

    task automatic run_ce(input int n, input int period);
        for (int i = 0; i < n; i++) begin
            ce = (i % period == 0);
            tick();
        end
        ce = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ce = 1'b0; ftw_in = '0; offset_in = '0; step_in = '0; len_in = '0;
        clear_strobes();
        model_reset();
        busy_cycles = 0;
        @(posedge clk);
        #1;
        check("reset_phase", 32'(o_phase), 32'h0);
        check("reset_busy",  32'(o_busy),  32'h0);
        chk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Ramp by one phase step per sample, including the 0xFF -> 0x00 wrap.
        do_reset();
        load(24'h010000, 8'h00);
        run_ce(258, 1);
        check("ramp_count", 32'(cap_phase.size()), 32'd258);
        check("ramp_p0",    32'(cap_phase[0]),   32'h00);
        check("ramp_p1",    32'(cap_phase[1]),   32'h01);
        check("ramp_p2",    32'(cap_phase[2]),   32'h02);
        check("ramp_pff",   32'(cap_phase[255]), 32'hFF);
        check("ramp_wff",   32'(cap_wrap[255]),  32'h1);
        check("ramp_p100",  32'(cap_phase[256]), 32'h00);
        check("ramp_w100",  32'(cap_wrap[256]),  32'h0);

        // Quarter-turn steps with offset.
        do_reset();
        load(24'h400000, 8'h10);
        run_ce(5, 1);
        check("quad_p0", 32'(cap_phase[0]), 32'h10);
        check("quad_p1", 32'(cap_phase[1]), 32'h50);
        check("quad_p2", 32'(cap_phase[2]), 32'h90);
        check("quad_p3", 32'(cap_phase[3]), 32'hD0);
        check("quad_w3", 32'(cap_wrap[3]),  32'h1);
        check("quad_p4", 32'(cap_phase[4]), 32'h10);
        check("quad_w4", 32'(cap_wrap[4]),  32'h0);

        // Sparse sample enable.
        do_reset();
        load(24'h010000, 8'h00);
        run_ce(12, 4);
        check("sparse_count", 32'(cap_phase.size()), 32'd3);
        check("sparse_p2",    32'(cap_phase[2]),     32'h02);

        // Linear sweep of three samples.
        do_reset();
        load(24'h010000, 8'h00);
        busy_cycles = 0;
        step_in = 24'h010000; len_in = 16'd3; sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        run_ce(6, 1);
        check("sweep_p1",   32'(cap_phase[1]), 32'h01);
        check("sweep_p2",   32'(cap_phase[2]), 32'h03);
        check("sweep_p3",   32'(cap_phase[3]), 32'h06);
        check("sweep_p4",   32'(cap_phase[4]), 32'h0A);
        check("sweep_p5",   32'(cap_phase[5]), 32'h0E);
        check("sweep_busy", 32'(busy_cycles),  32'd3);

        // Abort a long sweep with an FTW load.
        do_reset();
        load(24'h010000, 8'h00);
        step_in = 24'h010000; len_in = 16'd100; sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        run_ce(5, 1);
        ftw_in = 24'h020000; ftw_wr = 1'b1; ce = 1'b1;
        tick();
        ftw_wr = 1'b0;
        check("abort_busy", 32'(o_busy), 32'h0);
        run_ce(3, 1);
        check("abort_d1", 32'(cap_phase[7] - cap_phase[6]), 32'h2);
        check("abort_d2", 32'(cap_phase[8] - cap_phase[7]), 32'h2);

        // Start and load together: load wins.
        do_reset();
        load(24'h010000, 8'h00);
        busy_cycles = 0;
        step_in = 24'h010000; len_in = 16'd100; sweep_start = 1'b1;
        ftw_in = 24'h020000; ftw_wr = 1'b1;
        tick();
        clear_strobes();
        run_ce(3, 1);
        check("startwr_busy", 32'(busy_cycles), 32'd0);

        // Asynchronous reset in the middle of a sweep.
        do_reset();
        load(24'h010000, 8'h33);
        step_in = 24'h000100; len_in = 16'd100; sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        ce = 1'b1;
        tick(); tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("areset_phase", 32'(o_phase), 32'h0);
        check("areset_valid", 32'(o_valid), 32'h0);
        check("areset_wrap",  32'(o_wrap),  32'h0);
        check("areset_busy",  32'(o_busy),  32'h0);
        @(negedge clk);
        tick();
        rst = 1'b0;
        ce = 1'b0;

`ifdef SINTABLE_PHASE_GEN_SYNC_EN
        do_reset();
        load(24'h010000, 8'h05);
        run_ce(64, 1);
        sync = 1'b1; ce = 1'b1;
        tick();
        sync = 1'b0;
        run_ce(1, 1);
        check("sync_pre",  32'(cap_phase[64]), 32'h45);
        check("sync_post", 32'(cap_phase[65]), 32'h05);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ce          = ($urandom_range(0, 9) < 7);
            ftw_wr      = ($urandom_range(0, 49) == 0);
            ftw_in      = AW'($urandom);
            offset_wr   = ($urandom_range(0, 39) == 0);
            offset_in   = 8'($urandom);
            sweep_start = ($urandom_range(0, 14) == 0);
            step_in     = AW'($urandom_range(0, 'h3FFFF));
            len_in      = CW'($urandom_range(0, 12));
`ifdef SINTABLE_PHASE_GEN_SYNC_EN
            sync        = ($urandom_range(0, 63) == 0);
`endif
            tick();
        end
        clear_strobes();
        ce = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
